translayer_param: RTL and testbench

//  Parametrised transaction layer: one main FIFO routed to N_DEST destination FIFOs, selected by the data MSBs.

---
 rtl/translayer_param.sv | 185 ++++++++++++++++++
 tb/tb_translayer_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/translayer_param.sv
// Main FIFO feeding N_DEST egress FIFOs, with the destination taken from the data MSBs. Latency is one cycle
// from push to destination at best. A blocked head stalls the whole main FIFO, and pushes into a full main FIFO are dropped.
module translayer_param #(
    parameter int DATA_W     = 6,
    parameter int N_DEST     = 4,
    parameter int MAIN_DEPTH = 8,
    parameter int DEST_DEPTH = 4,
    localparam int SEL_W     = $clog2(N_DEST),
    localparam int CWM       = $clog2(MAIN_DEPTH + 1),
    localparam int CWD       = $clog2(DEST_DEPTH + 1),
    localparam int AWM       = $clog2(MAIN_DEPTH),
    localparam int AWD       = $clog2(DEST_DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       init,
    input  logic [2*CWM-1:0]           UMF,
    input  logic [2*CWD-1:0]           UD,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       push_main,
    input  logic [N_DEST-1:0]          pop_d,
    output logic [N_DEST*DATA_W-1:0]   data_out,
    output logic [N_DEST-1:0]          empty_d,
    output logic [N_DEST-1:0]          afull_d,
    output logic [N_DEST-1:0]          aempty_d,
    output logic                       afull_main,
    output logic                       aempty_main,
    output logic                       error_out,
    output logic                       active_out,
    output logic                       idle_out
);

    typedef enum logic [2:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR} state_t;
    state_t state, state_nxt;

    logic [CWM-1:0]    umf_lo, umf_hi;
    logic [CWD-1:0]    ud_lo, ud_hi;

    logic [DATA_W-1:0] main_mem [MAIN_DEPTH];
    logic [AWM-1:0]    main_wp, main_rp;
    logic [CWM-1:0]    main_cnt, main_cnt_nxt;
    logic              main_full, main_wr, route_mv;
    logic [DATA_W-1:0] head;
    logic [SEL_W-1:0]  head_sel;

    logic [DATA_W-1:0] dest_mem [N_DEST][DEST_DEPTH];
    logic [AWD-1:0]    dest_wp [N_DEST];
    logic [AWD-1:0]    dest_rp [N_DEST];
    logic [CWD-1:0]    dest_cnt [N_DEST];
    logic [CWD-1:0]    dest_cnt_nxt [N_DEST];
    logic [DATA_W-1:0] dout_r [N_DEST];
    logic [N_DEST-1:0] dest_full, dest_wr, dest_rd;

    logic run, push_err, pop_err, any_nxt;

    // Traffic is only honoured once initialisation is done; ERROR keeps moving data.
    assign run         = (state == ST_IDLE) || (state == ST_ACTIVE) || (state == ST_ERROR);
    assign head        = main_mem[main_rp];
    assign head_sel    = head[DATA_W-1 -: SEL_W];
    assign main_full   = (main_cnt == CWM'(MAIN_DEPTH));
    assign afull_main  = (main_cnt >= umf_hi);
    assign aempty_main = (main_cnt <= umf_lo);

    always_comb begin
        for (int k = 0; k < N_DEST; k++) begin
            empty_d[k]   = (dest_cnt[k] == '0);
            dest_full[k] = (dest_cnt[k] == CWD'(DEST_DEPTH));
            afull_d[k]   = (dest_cnt[k] >= ud_hi);
            aempty_d[k]  = (dest_cnt[k] <= ud_lo);
        end
    end

    // A full main FIFO still accepts a push when its head leaves in the same cycle.
    assign route_mv     = run && (main_cnt != '0) && !afull_d[head_sel] && !dest_full[head_sel];
    assign main_wr      = run && push_main && (!main_full || route_mv);
    assign push_err     = run && push_main && main_full && !route_mv;
    assign pop_err      = run && |(pop_d & empty_d);
    assign main_cnt_nxt = main_cnt + CWM'(main_wr) - CWM'(route_mv);

    always_comb begin
        any_nxt = (main_cnt_nxt != '0);
        for (int k = 0; k < N_DEST; k++) begin
            dest_wr[k]      = route_mv && (head_sel == SEL_W'(k));
            dest_rd[k]      = run && pop_d[k] && !empty_d[k];
            dest_cnt_nxt[k] = dest_cnt[k] + CWD'(dest_wr[k]) - CWD'(dest_rd[k]);
            if (dest_cnt_nxt[k] != '0) any_nxt = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_INIT;
            ST_INIT:   if (!init) state_nxt = ST_IDLE;
            ST_IDLE, ST_ACTIVE: begin
                if (init)                     state_nxt = ST_INIT;
                else if (push_err || pop_err) state_nxt = ST_ERROR;
                else if (any_nxt)             state_nxt = ST_ACTIVE;
                else                          state_nxt = ST_IDLE;
            end
            ST_ERROR:  if (init) state_nxt = ST_INIT;
            default:   state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_RESET;
        else        state <= state_nxt;
    end

    assign active_out = (state == ST_ACTIVE);
    assign idle_out   = (state == ST_IDLE);
    assign error_out  = (state == ST_ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            umf_lo <= '0;
            umf_hi <= '0;
            ud_lo  <= '0;
            ud_hi  <= '0;
        end else if (state == ST_INIT) begin
            umf_lo <= UMF[CWM-1:0];
            umf_hi <= UMF[2*CWM-1:CWM];
            ud_lo  <= UD[CWD-1:0];
            ud_hi  <= UD[2*CWD-1:CWD];
        end
    end

    // Storage arrays carry no reset; validity is tracked purely by pointers and counts.
    always_ff @(posedge clk) begin
        if (main_wr) main_mem[main_wp] <= data_in;
        for (int k = 0; k < N_DEST; k++)
            if (dest_wr[k]) dest_mem[k][dest_wp[k]] <= head;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_wp  <= '0;
            main_rp  <= '0;
            main_cnt <= '0;
        end else if (!run) begin
            main_wp  <= '0;
            main_rp  <= '0;
            main_cnt <= '0;
        end else begin
            if (main_wr)  main_wp <= main_wp + 1'b1;
            if (route_mv) main_rp <= main_rp + 1'b1;
            main_cnt <= main_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_DEST; k++) begin
                dest_wp[k]  <= '0;
                dest_rp[k]  <= '0;
                dest_cnt[k] <= '0;
                dout_r[k]   <= '0;
            end
        end else if (!run) begin
            for (int k = 0; k < N_DEST; k++) begin
                dest_wp[k]  <= '0;
                dest_rp[k]  <= '0;
                dest_cnt[k] <= '0;
                dout_r[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < N_DEST; k++) begin
                if (dest_wr[k]) dest_wp[k] <= dest_wp[k] + 1'b1;
                if (dest_rd[k]) begin
                    dest_rp[k] <= dest_rp[k] + 1'b1;
                    dout_r[k]  <= dest_mem[k][dest_rp[k]];
                end
                dest_cnt[k] <= dest_cnt_nxt[k];
            end
        end
    end

    always_comb begin
        data_out = '0;
        for (int k = 0; k < N_DEST; k++)
            data_out[k*DATA_W +: DATA_W] = dout_r[k];
    end

endmodule

// File: tb/tb_translayer_param.sv
// Directed bench for translayer_param; expected words are queued at push time and matched as they are popped.
module tb_translayer_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        init = 1'b0;
    logic [7:0]  UMF;
    logic [5:0]  UD;
    logic [5:0]  data_in = '0;
    logic        push_main = 1'b0;
    logic [3:0]  pop_d = '0;
    logic [23:0] data_out;
    logic [3:0]  empty_d, afull_d, aempty_d;
    logic        afull_main, aempty_main, error_out, active_out, idle_out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] dest;
        logic [5:0] dat;
    } exp_t;
    exp_t exp_q[$];

    translayer_param dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .UMF         (UMF),
        .UD          (UD),
        .data_in     (data_in),
        .push_main   (push_main),
        .pop_d       (pop_d),
        .data_out    (data_out),
        .empty_d     (empty_d),
        .afull_d     (afull_d),
        .aempty_d    (aempty_d),
        .afull_main  (afull_main),
        .aempty_main (aempty_main),
        .error_out   (error_out),
        .active_out  (active_out),
        .idle_out    (idle_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; accepted pushes are expected to reappear at dest d[5:4].
    task automatic step(input logic p, input logic [5:0] d, input logic [3:0] pops, input logic keep);
        @(posedge clk);
        #1;
        push_main = p;
        data_in   = d;
        pop_d     = pops;
        if (p && keep) exp_q.push_back({d[5:4], d});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            push_main = 1'b0;
            pop_d     = '0;
        end
    endtask

    task automatic pulse_init();
        @(posedge clk);
        #1;
        init = 1'b1;
        idle(1);
        init = 1'b0;
        idle(2);
    endtask

    // Monitor: every legal pop must present the oldest expected word for that destination.
    initial begin : monitor
        logic [3:0] fire;
        int idx;
        forever begin
            @(negedge clk);
            fire = pop_d & ~empty_d & {4{reset}};
            @(posedge clk);
            #2;
            for (int k = 0; k < 4; k++) begin
                if (fire[k]) begin
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (idx < 0 && exp_q[i].dest == k) idx = i;
                    if (idx < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_dest%0d: got %0h expected no word", k, data_out[k*6 +: 6]);
                    end else begin
                        check($sformatf("sb_dest%0d", k), data_out[k*6 +: 6], exp_q[idx].dat);
                        exp_q.delete(idx);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        UMF = {4'd6, 4'd1};
        UD  = {3'd3, 3'd1};

        // 1: reset, init, idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_error", error_out, 0);
        check("rst_idle", idle_out, 0);
        check("rst_active", active_out, 0);
        check("rst_data", data_out, 0);
        reset = 1'b1;
        init  = 1'b1;
        idle(2);
        init  = 1'b0;
        idle(2);
        check("t1_idle", idle_out, 1);
        check("t1_active", active_out, 0);
        check("t1_error", error_out, 0);
        check("t1_empty", empty_d, 4'hF);
        check("t1_afull_d", afull_d, 4'h0);
        check("t1_afull_main", afull_main, 0);
        check("t1_aempty_main", aempty_main, 1);

        // 2: one word per destination
        step(1, 6'h00, 4'h0, 1);
        step(1, 6'h11, 4'h0, 1);
        step(1, 6'h22, 4'h0, 1);
        step(1, 6'h33, 4'h0, 1);
        idle(3);
        check("t2_active", active_out, 1);
        check("t2_empty", empty_d, 4'h0);
        check("t2_aempty", aempty_d, 4'hF);
        step(0, 6'h00, 4'hF, 0);
        idle(1);
        check("t2_data_out", data_out, {6'h33, 6'h22, 6'h11, 6'h00});
        check("t2_idle", idle_out, 1);
        check("t2_empty_after", empty_d, 4'hF);
        idle(1);
        check("t2_sb_drained", exp_q.size(), 0);

        // 3: almost-full blocking and head-of-line stall
        step(1, 6'h01, 4'h0, 1);
        step(1, 6'h02, 4'h0, 1);
        step(1, 6'h03, 4'h0, 1);
        step(1, 6'h04, 4'h0, 1);
        step(1, 6'h15, 4'h0, 1);
        idle(4);
        check("t3_afull_d", afull_d, 4'b0001);
        check("t3_empty_hol", empty_d, 4'b1110);
        check("t3_aempty_d", aempty_d, 4'b1110);
        check("t3_aempty_main", aempty_main, 0);
        check("t3_afull_main", afull_main, 0);
        step(0, 6'h00, 4'b0001, 0);
        idle(4);
        check("t3_empty_drained", empty_d, 4'b1100);
        check("t3_afull_again", afull_d, 4'b0001);
        check("t3_main_empty", aempty_main, 1);
        step(0, 6'h00, 4'b0011, 0);
        step(0, 6'h00, 4'b0001, 0);
        step(0, 6'h00, 4'b0001, 0);
        idle(2);
        check("t3_sb_drained", exp_q.size(), 0);
        check("t3_idle", idle_out, 1);

        // 4: pop on empty, sticky error, init recovery
        step(0, 6'h00, 4'b0100, 0);
        idle(1);
        check("t4_error", error_out, 1);
        check("t4_not_idle", idle_out, 0);
        step(1, 6'h2A, 4'h0, 1);
        idle(3);
        step(0, 6'h00, 4'b0100, 0);
        idle(2);
        check("t4_error_sticky", error_out, 1);
        check("t4_sb_drained", exp_q.size(), 0);
        step(1, 6'h3B, 4'h0, 0);
        idle(2);
        check("t4_dest3_loaded", empty_d, 4'b0111);
        pulse_init();
        check("t4_error_cleared", error_out, 0);
        check("t4_idle", idle_out, 1);
        check("t4_flushed", empty_d, 4'hF);

        // 5: main full, drop on overflow, push+drain at full
        for (int i = 1; i <= 11; i++) step(1, 6'(i), 4'h0, 1);
        idle(3);
        check("t5_afull_main", afull_main, 1);
        check("t5_aempty_main", aempty_main, 0);
        check("t5_afull_d", afull_d, 4'b0001);
        check("t5_no_error", error_out, 0);
        step(0, 6'h00, 4'b0001, 0);
        step(1, 6'h0C, 4'h0, 1);
        idle(1);
        check("t5_push_drain_ok", error_out, 0);
        check("t5_still_full", afull_main, 1);
        step(1, 6'h0D, 4'h0, 0);
        idle(1);
        check("t5_overflow_error", error_out, 1);

        // 6: asynchronous reset with words in flight
        pulse_init();
        exp_q.delete();
        check("t6_init_idle", idle_out, 1);
        step(1, 6'h05, 4'h0, 1);
        step(1, 6'h16, 4'h0, 1);
        step(1, 6'h27, 4'h0, 1);
        step(1, 6'h38, 4'h0, 1);
        step(1, 6'h09, 4'h0, 1);
        idle(2);
        step(0, 6'h00, 4'b0001, 0);
        idle(1);
        check("t6_pre_data", data_out[5:0], 6'h05);
        #3;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_data", data_out, 0);
        check("t6_rst_error", error_out, 0);
        check("t6_rst_active", active_out, 0);
        check("t6_rst_idle", idle_out, 0);
        check("t6_rst_empty", empty_d, 4'hF);
        idle(2);
        reset = 1'b1;
        init  = 1'b1;
        idle(2);
        init  = 1'b0;
        idle(2);
        check("t6_idle", idle_out, 1);
        check("t6_empty", empty_d, 4'hF);
        check("t6_data", data_out, 0);
        step(1, 6'h3F, 4'h0, 1);
        idle(3);
        step(0, 6'h00, 4'b1000, 0);
        idle(2);
        check("t6_sb_drained", exp_q.size(), 0);
        check("t6_empty_end", empty_d, 4'hF);
        check("t6_idle_end", idle_out, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
